// File: rtl/booth_pp_stage.sv
// Radix-4 Booth encoder for 11x11 signed operands: 2-cycle elastic pipeline, full backpressure via pp_ready.
// BOOTH_PP_OPCNT_EN enables the saturating accepted-transaction counter on op_count.
module booth_pp_stage #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [10:0]      in_x,
   input  logic [10:0]      in_y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             pp_valid,
   input  logic             pp_ready,
   output logic [11:0]      pp_a,
   output logic [11:0]      pp_b,
   output logic [11:0]      pp_c,
   output logic [11:0]      pp_d,
   output logic [11:0]      pp_e,
   output logic [11:0]      pp_f,
   output logic             cin_a,
   output logic             cin_b,
   output logic             cin_c,
   output logic             cin_d,
   output logic             cin_e,
   output logic             cin_f,
   output logic [TAG_W-1:0] pp_tag,
   output logic [15:0]      op_count
);

   // Returns {cin, row}; negative digits invert and rely on cin for the +1.
   function automatic logic [12:0] booth_row(input logic [10:0] x, input logic [2:0] trip);
      logic [12:0] r;
      case (trip)
         3'b001, 3'b010: r = {1'b0, x[10], x};
         3'b011:         r = {1'b0, x, 1'b0};
         3'b100:         r = {1'b1, ~{x, 1'b0}};
         3'b101, 3'b110: r = {1'b1, ~{x[10], x}};
         default:        r = 13'h0000;
      endcase
      return r;
   endfunction

   logic                  s1_v_q, s1_v_d;
   logic                  s2_v_q, s2_v_d;
   logic [10:0]           s1_x_q, s1_y_q;
   logic [TAG_W-1:0]      s1_tag_q, s2_tag_q;
   logic [5:0][11:0]      rows_q, rows_d;
   logic [5:0]            cins_q, cins_d;
   logic [12:0]           y_ext;
   logic [12:0]           enc;
   logic                  s1_adv;
   logic                  accept;

   assign s1_adv   = s1_v_q & (~s2_v_q | pp_ready);
   assign in_ready = ~s1_v_q | s1_adv;
   assign accept   = in_valid & in_ready;

   // y[-1] = 0 at the bottom, y[11] = y[10] at the top.
   assign y_ext = {s1_y_q[10], s1_y_q, 1'b0};

   always_comb begin
      rows_d = '0;
      cins_d = '0;
      enc    = '0;
      for (int j = 0; j < 6; j++) begin
         enc       = booth_row(s1_x_q, y_ext[2*j +: 3]);
         rows_d[j] = enc[11:0];
         cins_d[j] = enc[12];
      end
   end

   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      if (flush) begin
         s1_v_d = 1'b0;
         s2_v_d = 1'b0;
      end else begin
         if (accept)
            s1_v_d = 1'b1;
         else if (s1_adv)
            s1_v_d = 1'b0;
         if (s1_adv)
            s2_v_d = 1'b1;
         else if (pp_ready)
            s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s1_x_q   <= '0;
         s1_y_q   <= '0;
         s1_tag_q <= '0;
         s2_tag_q <= '0;
         rows_q   <= '0;
         cins_q   <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         if (accept & ~flush) begin
            s1_x_q   <= in_x;
            s1_y_q   <= in_y;
            s1_tag_q <= in_tag;
         end
         if (s1_adv) begin
            rows_q   <= rows_d;
            cins_q   <= cins_d;
            s2_tag_q <= s1_tag_q;
         end
      end
   end

`ifdef BOOTH_PP_OPCNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept & ~flush & (cnt_q != 16'hFFFF))
         cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= 16'h0000;
      else
         cnt_q <= cnt_d;
   end

   assign op_count = cnt_q;
`else
   assign op_count = 16'h0000;
`endif

   assign pp_valid = s2_v_q;
   assign pp_tag   = s2_tag_q;
   assign pp_a     = rows_q[0];
   assign pp_b     = rows_q[1];
   assign pp_c     = rows_q[2];
   assign pp_d     = rows_q[3];
   assign pp_e     = rows_q[4];
   assign pp_f     = rows_q[5];
   assign cin_a    = cins_q[0];
   assign cin_b    = cins_q[1];
   assign cin_c    = cins_q[2];
   assign cin_d    = cins_q[3];
   assign cin_e    = cins_q[4];
   assign cin_f    = cins_q[5];

endmodule

// File: tb/tb_booth_pp_stage.sv
// Scoreboard bench for booth_pp_stage: hand-computed Booth rows, product reconstruction, stall stability, flush and reset.
module tb_booth_pp_stage;

   typedef struct packed {
      logic [3:0]  tag;
      logic [71:0] rows;
      logic [5:0]  cins;
      logic [10:0] x;
      logic [10:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, pp_valid, pp_ready;
   logic [10:0] in_x, in_y;
   logic [3:0]  in_tag, pp_tag;
   logic [11:0] pp_a, pp_b, pp_c, pp_d, pp_e, pp_f;
   logic        cin_a, cin_b, cin_c, cin_d, cin_e, cin_f;
   logic [15:0] op_count;

   logic [10:0] vx [10];
   logic [10:0] vy [10];
   logic [71:0] vr [10];
   logic [5:0]  vc [10];

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          n_acc = 0;
   int          mode = 2;
   bit          discard = 0;

   booth_pp_stage #(.TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
      .pp_valid(pp_valid), .pp_ready(pp_ready),
      .pp_a(pp_a), .pp_b(pp_b), .pp_c(pp_c), .pp_d(pp_d), .pp_e(pp_e), .pp_f(pp_f),
      .cin_a(cin_a), .cin_b(cin_b), .cin_c(cin_c), .cin_d(cin_d), .cin_e(cin_e), .cin_f(cin_f),
      .pp_tag(pp_tag), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
      n_chk++;
      if (act === expv)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, expv);
   endtask

   function automatic longint recon(input logic [71:0] rows, input logic [5:0] cins);
      longint s = 0;
      for (int j = 0; j < 6; j++)
         s += (longint'($signed(rows[12*j +: 12])) + longint'(cins[j])) * (longint'(1) << (2*j));
      return s;
   endfunction

   function automatic logic [81:0] outs();
      return {pp_tag, pp_f, pp_e, pp_d, pp_c, pp_b, pp_a, cin_f, cin_e, cin_d, cin_c, cin_b, cin_a};
   endfunction

   // Consumer ready pattern: 0 always ready, 1 random, 2 stalled.
   initial begin
      pp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       pp_ready = 1'b1;
            1:       pp_ready = 1'($urandom_range(0, 1));
            default: pp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops on every handshake, checks rows and that stalled outputs hold.
   initial begin
      exp_t        e;
      bit          stalled = 0;
      logic [81:0] held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 0;
         end else begin
            if (stalled && pp_valid)
               chk("stall_hold", 96'(outs()), 96'(held));
            if (pp_valid && pp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 96'(outs()), 96'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rows_tag", 96'(outs()), 96'({e.tag, e.rows, e.cins}));
                  chk("product", 96'(recon({pp_f, pp_e, pp_d, pp_c, pp_b, pp_a},
                                           {cin_f, cin_e, cin_d, cin_c, cin_b, cin_a})),
                      96'(longint'($signed(e.x)) * longint'($signed(e.y))));
               end
            end
            stalled = pp_valid && !pp_ready;
            held    = outs();
         end
      end
   end

   task automatic send(input int idx, input logic [3:0] tag, output int waits);
      bit   acc = 0;
      exp_t e;
      in_valid = 1'b1;
      in_x     = vx[idx];
      in_y     = vy[idx];
      in_tag   = tag;
      waits    = 0;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            if (n_acc < 65535) n_acc++;
            if (!discard) begin
               e.tag = tag; e.rows = vr[idx]; e.cins = vc[idx]; e.x = vx[idx]; e.y = vy[idx];
               exp_q.push_back(e);
            end
         end
         @(posedge clk);
         #1;
         if (!acc) begin
            waits++;
            if (waits > 200) begin
               chk("send_timeout", 96'(waits), 96'd0);
               acc = 1;
            end
         end
      end
      in_valid = 1'b0;
      in_x     = 11'($urandom);
      in_y     = 11'($urandom);
   endtask

   task automatic drain();
      int cnt = 0;
      while (exp_q.size() > 0 && cnt < 500) begin
         @(posedge clk);
         cnt++;
      end
      chk("drain", 96'(exp_q.size()), 96'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int w, wsum;
      //        x             y            rows {f,e,d,c,b,a}                                   cins
      vx[0] = 11'd3;   vy[0] = 11'd5;   vr[0] = {12'h0, 12'h0, 12'h0, 12'h0, 12'h003, 12'h003}; vc[0] = 6'b000000;
      vx[1] = 11'h7FF; vy[1] = 11'h7FF; vr[1] = {12'h0, 12'h0, 12'h0, 12'h0, 12'h000, 12'h000}; vc[1] = 6'b000001;
      vx[2] = 11'h400; vy[2] = 11'h400; vr[2] = {12'h3FF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};   vc[2] = 6'b100000;
      vx[3] = 11'd5;   vy[3] = 11'd2;   vr[3] = {12'h0, 12'h0, 12'h0, 12'h0, 12'h005, 12'hFF5}; vc[3] = 6'b000001;
      vx[4] = 11'h3FF; vy[4] = 11'h3FF; vr[4] = {12'h3FF, 12'h0, 12'h0, 12'h0, 12'h0, 12'hC00}; vc[4] = 6'b000001;
      vx[5] = 11'h400; vy[5] = 11'd3;   vr[5] = {12'h0, 12'h0, 12'h0, 12'h0, 12'hC00, 12'h3FF}; vc[5] = 6'b000001;
      vx[6] = 11'd7;   vy[6] = 11'd6;   vr[6] = {12'h0, 12'h0, 12'h0, 12'h0, 12'h00E, 12'hFF1}; vc[6] = 6'b000001;
      vx[7] = 11'h7FD; vy[7] = 11'h7FC; vr[7] = {12'h0, 12'h0, 12'h0, 12'h0, 12'h002, 12'h000}; vc[7] = 6'b000010;
      vx[8] = 11'd0;   vy[8] = 11'h400; vr[8] = {12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};   vc[8] = 6'b100000;
      vx[9] = 11'h400; vy[9] = 11'h600; vr[9] = {12'h0, 12'h7FF, 12'h0, 12'h0, 12'h0, 12'h0};   vc[9] = 6'b010000;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_tag = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_pp_valid", 96'(pp_valid), 96'd0);
      chk("reset_in_ready", 96'(in_ready), 96'd1);
      chk("reset_outputs", 96'(outs()), 96'd0);
      chk("reset_op_count", 96'(op_count), 96'd0);

      // Random backpressure with idle gaps carrying garbage data.
      @(posedge clk); #1;
      mode = 1;
      for (int i = 0; i < 10; i++) begin
         send(i, 4'(i), w);
         if (i % 3 == 1) begin
            in_x = 11'($urandom); in_y = 11'($urandom);
            @(posedge clk); #1;
         end
      end
      drain();

      // Full throughput: no waits when the consumer is always ready.
      mode = 0;
      @(posedge clk); #1;
      wsum = 0;
      for (int i = 0; i < 6; i++) begin
         send(9 - i, 4'(10 + i), w);
         wsum += w;
      end
      chk("throughput_waits", 96'(wsum), 96'd0);
      drain();

      // Fill both stages, then flush.
      mode = 2;
      repeat (2) @(posedge clk);
      #1;
      discard = 1;
      send(0, 4'hA, w);
      chk("latency_n1", 96'(pp_valid), 96'd0);
      send(1, 4'hB, w);
      @(negedge clk);
      chk("full_in_ready", 96'(in_ready), 96'd0);
      chk("full_pp_valid", 96'(pp_valid), 96'd1);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; in_x = vx[3]; in_y = vy[3]; in_tag = 4'hC;
      @(negedge clk);
      chk("flush_in_ready_full", 96'(in_ready), 96'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_pp_valid", 96'(pp_valid), 96'd0);
      @(posedge clk); #1;
      flush = 1'b1; in_valid = 1'b1; in_tag = 4'hD;
      @(negedge clk);
      chk("flush_in_ready_empty", 96'(in_ready), 96'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("flushed_accept_dropped", 96'(pp_valid), 96'd0);
`ifdef BOOTH_PP_OPCNT_EN
      chk("op_count_flush", 96'(op_count), 96'(n_acc));
`else
      chk("op_count_flush", 96'(op_count), 96'd0);
`endif

      // Asynchronous reset with a pair sitting in stage 2.
      @(posedge clk); #1;
      send(2, 4'hE, w);
      @(posedge clk); #1;
      chk("latency_n2", 96'(pp_valid), 96'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_pp_valid", 96'(pp_valid), 96'd0);
      chk("async_rst_outputs", 96'(outs()), 96'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      discard = 0;
      n_acc = 0;
      mode = 0;
      @(posedge clk); #1;
      send(3, 4'h3, w);
      send(4, 4'h4, w);
      drain();
`ifdef BOOTH_PP_OPCNT_EN
      chk("op_count_final", 96'(op_count), 96'd2);
`else
      chk("op_count_final", 96'(op_count), 96'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
